// File: rtl/dither_pkg.sv
// Shared definitions for the multi-channel requantiser: mode codes, FSM states
// and the feedback mask for the 32-bit Galois LFSRs.
`timescale 1ns/1ps
package dither_pkg;

   localparam logic [1:0] MODE_ROUND = 2'd0;
   localparam logic [1:0] MODE_TPDF  = 2'd1;
   localparam logic [1:0] MODE_NS1   = 2'd2;
   localparam logic [1:0] MODE_NS2   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PROC,
      ST_DONE
   } state_e;

   // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

endpackage

// File: rtl/dither_lfsr32.sv
// 32-bit Galois LFSR that advances one step per cycle while step_i is high.
`timescale 1ns/1ps
module dither_lfsr32
   import dither_pkg::*;
#(
   parameter logic [31:0] SEED = 32'h0000_0001
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        step_i,
   output logic [31:0] state_o
);

   logic [31:0] lfsr_q;
   logic [31:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (step_i) begin
         lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign state_o = lfsr_q;

endmodule

// File: rtl/dither_ns_mc.sv
// Multi-channel requantiser: round / TPDF dither / TPDF with 1st or 2nd order
// error-feedback shaping, one shared datapath stepping through one channel per clock.
`timescale 1ns/1ps
module dither_ns_mc
   import dither_pkg::*;
#(
   parameter int          IN_W     = 40,
   parameter int          OUT_W    = 16,
   parameter int          CHANNELS = 2,
   parameter logic [31:0] SEED_A   = 32'hACE1_2345,
   parameter logic [31:0] SEED_B   = 32'h1357_9BDF
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      wren_i,
   input  logic [1:0]                mode_i,
   input  logic [CHANNELS*IN_W-1:0]  in_i,
   output logic [CHANNELS*OUT_W-1:0] out_o,
   output logic                      valid_o,
   output logic                      busy_o,
   output logic [CHANNELS-1:0]       clip_o,
   output logic                      overrun_o
);

   localparam int FRAC_W = IN_W - OUT_W;
   localparam int AW     = IN_W + 4;
   localparam int EW     = FRAC_W + 3;
   localparam int CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   localparam logic signed [AW-1:0] ONE_F  = AW'(1) <<< FRAC_W;
   localparam logic signed [AW-1:0] HALF_F = ONE_F >>> 1;
   localparam logic signed [AW-1:0] E_LIM  = ONE_F <<< 1;
   localparam logic signed [AW-1:0] Q_MAX  = (AW'(1) <<< (OUT_W - 1)) - AW'(1);
   localparam logic signed [AW-1:0] Q_MIN  = -Q_MAX - AW'(1);

   state_e                    state_q;
   logic [CW-1:0]             ch_q;
   logic [1:0]                mode_q;
   logic [CHANNELS*IN_W-1:0]  inBuf_q;
   logic [CHANNELS*OUT_W-1:0] outAcc_q, outAcc_d, out_q;
   logic [CHANNELS-1:0]       clipAcc_q, clipAcc_d, clip_q;
   logic                      valid_q, busy_q, overrun_q;
   logic signed [EW-1:0]      e1_q [CHANNELS];
   logic signed [EW-1:0]      e2_q [CHANNELS];

   logic [31:0]               lfsrA, lfsrB;
   logic signed [IN_W-1:0]    xRaw;
   logic signed [AW-1:0]      x, e1, e2, v, uA, uB, d, w, q, qSat, eFull, eClamp;
   logic signed [EW-1:0]      eNew;
   logic                      sat, lastCh, stepLfsr;
   logic                      unusedBits;

   assign stepLfsr = (state_q == ST_PROC);

   dither_lfsr32 #(.SEED(SEED_A)) uLfsrA (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .step_i  (stepLfsr),
      .state_o (lfsrA)
   );

   dither_lfsr32 #(.SEED(SEED_B)) uLfsrB (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .step_i  (stepLfsr),
      .state_o (lfsrB)
   );

   // Datapath for the channel currently selected by ch_q.
   always_comb begin
      xRaw = inBuf_q[ch_q*IN_W +: IN_W];
      x    = AW'(xRaw);
      e1   = AW'(e1_q[ch_q]);
      e2   = AW'(e2_q[ch_q]);
      case (mode_q)
         MODE_NS1: v = x - e1;
         MODE_NS2: v = x - (e1 <<< 1) + e2;
         default:  v = x;
      endcase
      uA = AW'(lfsrA[FRAC_W-1:0]);
      uB = AW'(lfsrB[FRAC_W-1:0]);
      d  = (mode_q == MODE_ROUND) ? '0 : (uA + uB - ONE_F);
      w  = v + d;
      q  = (w + HALF_F) >>> FRAC_W;
      sat  = 1'b1;
      if (q > Q_MAX) begin
         qSat = Q_MAX;
      end else if (q < Q_MIN) begin
         qSat = Q_MIN;
      end else begin
         qSat = q;
         sat  = 1'b0;
      end
      eFull = w - (qSat <<< FRAC_W);
      if (eFull > E_LIM) begin
         eClamp = E_LIM;
      end else if (eFull < -E_LIM) begin
         eClamp = -E_LIM;
      end else begin
         eClamp = eFull;
      end
      eNew = EW'(eClamp);
      outAcc_d = outAcc_q;
      outAcc_d[ch_q*OUT_W +: OUT_W] = qSat[OUT_W-1:0];
      clipAcc_d = clipAcc_q;
      clipAcc_d[ch_q] = sat;
      lastCh = (ch_q == CW'(CHANNELS - 1));
   end

   assign unusedBits = ^{lfsrA, lfsrB, qSat};

   // Frame FSM; a mode change between frames wipes all error history.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         ch_q      <= '0;
         mode_q    <= MODE_ROUND;
         inBuf_q   <= '0;
         outAcc_q  <= '0;
         clipAcc_q <= '0;
         out_q     <= '0;
         clip_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         for (int k = 0; k < CHANNELS; k++) begin
            e1_q[k] <= '0;
            e2_q[k] <= '0;
         end
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               state_q <= ST_IDLE;
               if (wren_i) begin
                  state_q   <= ST_PROC;
                  busy_q    <= 1'b1;
                  ch_q      <= '0;
                  inBuf_q   <= in_i;
                  mode_q    <= mode_i;
                  clipAcc_q <= '0;
                  if (mode_i != mode_q) begin
                     for (int k = 0; k < CHANNELS; k++) begin
                        e1_q[k] <= '0;
                        e2_q[k] <= '0;
                     end
                  end
               end
            end
            ST_PROC: begin
               if (wren_i) begin
                  overrun_q <= 1'b1;
               end
               outAcc_q  <= outAcc_d;
               clipAcc_q <= clipAcc_d;
               if (mode_q == MODE_NS1 || mode_q == MODE_NS2) begin
                  e2_q[ch_q] <= e1_q[ch_q];
                  e1_q[ch_q] <= eNew;
               end
               if (lastCh) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  valid_q <= 1'b1;
                  out_q   <= outAcc_d;
                  clip_q  <= clipAcc_d;
               end else begin
                  ch_q <= ch_q + CW'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign out_o     = out_q;
   assign valid_o   = valid_q;
   assign busy_o    = busy_q;
   assign clip_o    = clip_q;
   assign overrun_o = overrun_q;

endmodule

// File: tb/tb_dither_ns_mc.sv
// Randomised self-checking bench for dither_ns_mc against a frame-level arithmetic
// model of the requantiser (default parameters, two channels, 24 fractional bits).
`timescale 1ns/1ps
module tb_dither_ns_mc;

   localparam int     CH     = 2;
   localparam longint ONE_F  = 64'sd1 <<< 24;
   localparam longint HALF_F = 64'sd1 <<< 23;

   logic        clk = 1'b0;
   logic        rst;
   logic        wren;
   logic [1:0]  mode;
   logic [79:0] inData;
   logic [31:0] out;
   logic        valid, busy, overrun;
   logic [1:0]  clip;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mA, mB;
   longint      e1m [CH];
   longint      e2m [CH];
   logic [1:0]  mPrev;
   logic [15:0] expOut [CH];
   logic [1:0]  expClip;

   dither_ns_mc dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .wren_i    (wren),
      .mode_i    (mode),
      .in_i      (inData),
      .out_o     (out),
      .valid_o   (valid),
      .busy_o    (busy),
      .clip_o    (clip),
      .overrun_o (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] lfsrNext(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   task automatic modelReset();
      mA = 32'hACE1_2345;
      mB = 32'h1357_9BDF;
      mPrev = 2'd0;
      for (int k = 0; k < CH; k++) begin
         e1m[k] = 0;
         e2m[k] = 0;
      end
   endtask

   // One whole frame of the reference: plain integer arithmetic per channel.
   task automatic modelFrame(input logic [1:0] m, input logic [79:0] data);
      longint x, v, dth, w, q, e;
      logic signed [39:0] s;
      if (m != mPrev) begin
         for (int k = 0; k < CH; k++) begin
            e1m[k] = 0;
            e2m[k] = 0;
         end
      end
      mPrev = m;
      expClip = 2'b00;
      for (int k = 0; k < CH; k++) begin
         s = data[k*40 +: 40];
         x = longint'(s);
         if (m == 2'd2) v = x - e1m[k];
         else if (m == 2'd3) v = x - 2 * e1m[k] + e2m[k];
         else v = x;
         dth = (m == 2'd0) ? 0 : (longint'(mA[23:0]) + longint'(mB[23:0]) - ONE_F);
         w = v + dth;
         q = (w + HALF_F) >>> 24;
         if (q > 32767) begin
            q = 32767;
            expClip[k] = 1'b1;
         end else if (q < -32768) begin
            q = -32768;
            expClip[k] = 1'b1;
         end
         e = w - q * ONE_F;
         if (e > 2 * ONE_F) e = 2 * ONE_F;
         if (e < -2 * ONE_F) e = -2 * ONE_F;
         if (m >= 2'd2) begin
            e2m[k] = e1m[k];
            e1m[k] = e;
         end
         expOut[k] = q[15:0];
         mA = lfsrNext(mA);
         mB = lfsrNext(mB);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkFrameResult();
      checkOutput("valid", valid, 1'b1);
      checkOutput("busyDone", busy, 1'b0);
      for (int k = 0; k < CH; k++) begin
         checkOutput($sformatf("out ch%0d", k), out[k*16 +: 16], expOut[k]);
      end
      checkOutput("clip", clip, expClip);
   endtask

   // Called in cycle 0 (just after an edge); returns in cycle 3 with outputs checked.
   task automatic applyStimulus(input logic [1:0] m, input logic [79:0] data);
      wren = 1'b1;
      mode = m;
      inData = data;
      modelFrame(m, data);
      tick();
      wren = 1'b0;
      inData = {$urandom(), $urandom(), $urandom()};
      mode = 2'($urandom());
      checkOutput("busyC1", busy, 1'b1);
      checkOutput("validC1", valid, 1'b0);
      tick();
      checkOutput("busyC2", busy, 1'b1);
      checkOutput("validC2", valid, 1'b0);
      tick();
      checkFrameResult();
   endtask

   function automatic logic [39:0] randSample();
      case ($urandom_range(0, 3))
         0: return 40'($signed($urandom()));
         1: return 40'({$urandom(), $urandom()});
         2: return $urandom_range(0, 1) ? (40'h7F_FFFF_FFFF - 40'($urandom_range(0, 1 << 24)))
                                        : (40'h80_0000_0000 + 40'($urandom_range(0, 1 << 24)));
         default: return 40'(longint'($signed($urandom())) >>> 6);
      endcase
   endfunction

   initial begin
      logic [1:0] rm;
      int         sum;
      real        avg;
      logic [15:0] o;

      rst = 1'b1;
      wren = 1'b0;
      mode = 2'd0;
      inData = '0;
      tick();
      tick();
      checkOutput("rstOut", out, 32'h0);
      checkOutput("rstValid", valid, 1'b0);
      checkOutput("rstBusy", busy, 1'b0);
      checkOutput("rstClip", clip, 2'b00);
      checkOutput("rstOverrun", overrun, 1'b0);
      rst = 1'b0;
      modelReset();
      tick();

      $display("[TB] rounding and saturation");
      applyStimulus(2'd0, {40'hFF_FF80_0000, 40'h00_0080_0000});
      checkOutput("halfUpPos", out[15:0], 16'h0001);
      checkOutput("halfUpNeg", out[31:16], 16'h0000);
      checkOutput("noClip", clip, 2'b00);
      applyStimulus(2'd0, {40'hFF_FF7F_FFFF, 40'h00_007F_FFFF});
      applyStimulus(2'd0, {40'h80_0000_0000, 40'h7F_FFFF_FFFF});
      checkOutput("satHi", out[15:0], 16'h7FFF);
      checkOutput("satLo", out[31:16], 16'h8000);
      checkOutput("clipHi", clip[0], 1'b1);
      for (int i = 0; i < 8; i++) applyStimulus(2'd1, {40'h80_0000_0000, 40'h7F_FFFF_FFFF});

      $display("[TB] TPDF on silence");
      sum = 0;
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(2'd1, 80'h0);
         for (int k = 0; k < CH; k++) begin
            o = out[k*16 +: 16];
            sum += int'($signed(o));
            checkOutput("tpdfRange", (o == 16'h0000 || o == 16'h0001 || o == 16'hFFFF), 1'b1);
         end
      end
      avg = real'(sum) / 6000.0;
      checkOutput("tpdfMean", (avg < 0.05 && avg > -0.05), 1'b1);

      $display("[TB] noise shaping, constant quarter LSB");
      for (int i = 0; i < 1024; i++) applyStimulus(2'd2, {40'h00_0040_0000, 40'h00_0040_0000});
      for (int i = 0; i < 1024; i++) applyStimulus(2'd3, {40'h00_0040_0000, 40'h00_0040_0000});

      $display("[TB] randomised frames");
      rm = 2'd2;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) rm = 2'($urandom());
         applyStimulus(rm, {randSample(), randSample()});
      end

      $display("[TB] overrun");
      wren = 1'b1;
      mode = 2'd2;
      inData = {40'h00_1234_5678, 40'hFF_8765_4321};
      modelFrame(2'd2, inData);
      tick();
      inData = {40'h7F_0000_0000, 40'h80_0000_0000};
      mode = 2'd0;
      checkOutput("ovrBusy", busy, 1'b1);
      tick();
      wren = 1'b0;
      checkOutput("ovrSet", overrun, 1'b1);
      tick();
      checkFrameResult();
      applyStimulus(2'd2, {40'h00_0000_1000, 40'h00_0300_0000});
      checkOutput("ovrSticky", overrun, 1'b1);

      $display("[TB] reset mid-frame");
      wren = 1'b1;
      mode = 2'd3;
      inData = {40'h7F_FFFF_FFFF, 40'h7F_FFFF_FFFF};
      tick();
      wren = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("abortValid", valid, 1'b0);
      checkOutput("abortOut", out, 32'h0);
      checkOutput("abortClip", clip, 2'b00);
      checkOutput("abortBusy", busy, 1'b0);
      checkOutput("abortOverrun", overrun, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("abortNoValid", valid, 1'b0);
      end
      modelReset();
      for (int i = 0; i < 256; i++) applyStimulus(2'd2, {40'h00_0040_0000, 40'h00_0040_0000});

      $display("[TB] wren with rst");
      rst = 1'b1;
      wren = 1'b1;
      mode = 2'd1;
      tick();
      rst = 1'b0;
      wren = 1'b0;
      checkOutput("rstWinsBusy", busy, 1'b0);
      tick();
      checkOutput("rstWinsIdle", busy, 1'b0);
      checkOutput("rstWinsValid", valid, 1'b0);
      modelReset();
      applyStimulus(2'd1, {40'h00_0000_0000, 40'h00_0100_0000});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
